// File: rtl/bp_btb_fetch_pkg.sv
// Shared branch-prediction types and constants for the BTB fetch block and
// the global-history direction predictor.
package bp_pkg;

    localparam int unsigned SET_W    = 5;
    localparam int unsigned HASH_W   = 3;
    localparam int unsigned FALLTHRU = 8;
    localparam int unsigned NSETS    = 1 << SET_W;
    localparam int unsigned TAG_W    = 32 - SET_W - 2;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
    } btb_entry_t;

    typedef struct packed {
        logic        taken;
        logic [31:0] pc;
    } pred_t;

    // Takes pc[2*HASH_W+1:2]; folds the two low word-address fields together.
    function automatic logic [HASH_W-1:0] bp_hash(input logic [2*HASH_W-1:0] wa);
        return wa[HASH_W-1:0] ^ wa[2*HASH_W-1:HASH_W];
    endfunction

endpackage

// File: rtl/bp_btb_fetch_if.sv
// Fetch/M-stage signal bundle between the pipeline and the BTB predictor.
interface bp_btb_fetch_if;
    import bp_pkg::*;

    logic [31:0]       pcF;
    logic              pcsrcPF;
    logic [HASH_W-1:0] hashed_pcF;
    logic              btb_hitF;
    logic              pred_takenF;
    logic [31:0]       pred_pcF;
    logic              stallD;
    logic              flushD;
    logic              flushE;
    logic              flushM;
    logic              branchM;
    logic [31:0]       pcM;
    logic              pcsrcM;
    logic [31:0]       targetM;
    logic [HASH_W-1:0] hashed_pcM;
    logic              pcsrcPM;
    logic              mispredM;
    logic [31:0]       correct_pcM;

    modport master (
        output pcF, pcsrcPF, stallD, flushD, flushE, flushM,
               branchM, pcM, pcsrcM, targetM,
        input  hashed_pcF, btb_hitF, pred_takenF, pred_pcF,
               hashed_pcM, pcsrcPM, mispredM, correct_pcM
    );

    modport slave (
        input  pcF, pcsrcPF, stallD, flushD, flushE, flushM,
               branchM, pcM, pcsrcM, targetM,
        output hashed_pcF, btb_hitF, pred_takenF, pred_pcF,
               hashed_pcM, pcsrcPM, mispredM, correct_pcM
    );
endinterface

// File: rtl/bp_btb_fetch_btb_array.sv
// 2-way set-associative BTB storage: asynchronous lookup, victim selection
// and LRU update on taken-branch training.
module bp_btb_array
    import bp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] lkWa,
    output logic        hit,
    output logic [31:0] hitTarget,
    input  logic        wrEn,
    input  logic [29:0] wrWa,
    input  logic [31:0] wrTarget
);

    btb_entry_t       mem0 [NSETS];
    btb_entry_t       mem1 [NSETS];
    logic [NSETS-1:0] lru;

    logic [SET_W-1:0] lkSet, wrSet;
    logic [TAG_W-1:0] lkTag, wrTag;
    logic             hit0, hit1, wrHit0, wrHit1, victim;

    assign lkSet = lkWa[SET_W-1:0];
    assign lkTag = lkWa[29:SET_W];
    assign wrSet = wrWa[SET_W-1:0];
    assign wrTag = wrWa[29:SET_W];

    // Lookup: a tag is only ever installed in one way, so at most one hits.
    assign hit0      = mem0[lkSet].valid && (mem0[lkSet].tag == lkTag);
    assign hit1      = mem1[lkSet].valid && (mem1[lkSet].tag == lkTag);
    assign hit       = hit0 | hit1;
    assign hitTarget = hit1 ? mem1[lkSet].target : mem0[lkSet].target;

    assign wrHit0 = mem0[wrSet].valid && (mem0[wrSet].tag == wrTag);
    assign wrHit1 = mem1[wrSet].valid && (mem1[wrSet].tag == wrTag);

    // Victim: hitting way, else first invalid way, else the LRU way.
    always_comb begin
        victim = lru[wrSet];
        if (wrHit0)                   victim = 1'b0;
        else if (wrHit1)              victim = 1'b1;
        else if (!mem0[wrSet].valid)  victim = 1'b0;
        else if (!mem1[wrSet].valid)  victim = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < int'(NSETS); s++) begin
                mem0[s] <= '0;
                mem1[s] <= '0;
            end
            lru <= '0;
        end else if (wrEn) begin
            if (victim) mem1[wrSet] <= '{valid: 1'b1, tag: wrTag, target: wrTarget};
            else        mem0[wrSet] <= '{valid: 1'b1, tag: wrTag, target: wrTarget};
            lru[wrSet] <= ~victim;
        end
    end

endmodule

// File: rtl/bp_btb_fetch.sv
// Fetch-stage BTB and next-PC predictor: F lookup, prediction pipeline to M,
// and M-stage mispredict check plus BTB training.
module bp_btb_fetch
    import bp_pkg::*;
(
    input logic          clk,
    input logic          rst,
    bp_btb_fetch_if.slave bus
);

    logic        hitF;
    logic [31:0] hitTargetF;
    pred_t       predF, predD, predE, predM;

    bp_btb_array uArray (
        .clk       (clk),
        .rst       (rst),
        .lkWa      (bus.pcF[31:2]),
        .hit       (hitF),
        .hitTarget (hitTargetF),
        .wrEn      (bus.branchM & bus.pcsrcM),
        .wrWa      (bus.pcM[31:2]),
        .wrTarget  (bus.targetM)
    );

    assign bus.hashed_pcF  = bp_hash(bus.pcF[2*HASH_W+1:2]);
    assign bus.hashed_pcM  = bp_hash(bus.pcM[2*HASH_W+1:2]);
    assign bus.btb_hitF    = hitF;
    assign bus.pred_takenF = hitF & bus.pcsrcPF;
    assign bus.pred_pcF    = bus.pred_takenF ? hitTargetF : bus.pcF + 32'd4;

    assign predF.taken = bus.pred_takenF;
    assign predF.pc    = bus.pred_pcF;

    // Prediction travels with the instruction; flush beats stall in D.
    always_ff @(posedge clk) begin
        if (rst || bus.flushD)  predD <= '0;
        else if (!bus.stallD)   predD <= predF;

        if (rst || bus.flushE)  predE <= '0;
        else                    predE <= predD;

        if (rst || bus.flushM)  predM <= '0;
        else                    predM <= predE;
    end

    assign bus.pcsrcPM     = predM.taken;
    assign bus.mispredM    = bus.branchM &
                             ((predM.taken != bus.pcsrcM) |
                              (bus.pcsrcM & (predM.pc != bus.targetM)));
    assign bus.correct_pcM = bus.pcsrcM ? bus.targetM : bus.pcM + 32'(FALLTHRU);

endmodule

// File: tb/tb_bp_btb_fetch.sv
// Directed bench for bp_btb_fetch: the driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the live outputs.
module tb_bp_btb_fetch;
    import bp_pkg::*;

    localparam int S_HIT = 0, S_PPC = 1, S_TAKEN = 2, S_HF = 3,
                   S_PSM = 4, S_MIS = 5, S_CPC = 6, S_HM = 7;

    typedef struct {
        int          sig;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    bp_btb_fetch_if bus();

    bp_btb_fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic setF(input logic [31:0] pc, input logic p);
        bus.pcF     = pc;
        bus.pcsrcPF = p;
    endtask

    task automatic setM(input logic b, input logic [31:0] pc, input logic s,
                        input logic [31:0] t);
        bus.branchM = b;
        bus.pcM     = pc;
        bus.pcsrcM  = s;
        bus.targetM = t;
    endtask

    function automatic void ex(input int sig, input logic [31:0] v, input string nm);
        exp_t e;
        e.sig  = sig;
        e.val  = v;
        e.name = nm;
        q.push_back(e);
    endfunction

    // Monitor: consume every expectation queued for the current cycle.
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                case (e.sig)
                    S_HIT:   act = 32'(bus.btb_hitF);
                    S_PPC:   act = bus.pred_pcF;
                    S_TAKEN: act = 32'(bus.pred_takenF);
                    S_HF:    act = 32'(bus.hashed_pcF);
                    S_PSM:   act = 32'(bus.pcsrcPM);
                    S_MIS:   act = 32'(bus.mispredM);
                    S_CPC:   act = bus.correct_pcM;
                    default: act = 32'(bus.hashed_pcM);
                endcase
                checks++;
                if (act !== e.val) begin
                    failures++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h at %0t",
                             e.name, act, e.val, $time);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        setF(32'h0, 1'b0);
        setM(1'b0, 32'h0, 1'b0, 32'h0);
        bus.stallD = 1'b0;
        bus.flushD = 1'b0;
        bus.flushE = 1'b0;
        bus.flushM = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;

        // Reset state
        setF(32'h0040_0000, 1'b1);
        ex(S_HIT, 32'd0, "reset_hit");
        ex(S_PPC, 32'h0040_0004, "reset_pred_pc");
        ex(S_TAKEN, 32'd0, "reset_taken");
        ex(S_MIS, 32'd0, "reset_mispred");
        ex(S_PSM, 32'd0, "reset_pcsrcPM");
        ex(S_HF, 32'd0, "reset_hashF");
        cyc();

        // Hashing and not-taken fall-through
        setF(32'h0000_00E4, 1'b1);
        setM(1'b0, 32'h0000_00E4, 1'b0, 32'h0);
        ex(S_HF, 32'd6, "hashF_e4");
        ex(S_HM, 32'd6, "hashM_e4");
        ex(S_CPC, 32'h0000_00EC, "fallthru_pc");
        ex(S_MIS, 32'd0, "no_branch_mispred");
        cyc();

        // Allocate: taken branch with no prediction
        setF(32'h0040_0010, 1'b1);
        setM(1'b1, 32'h0040_0010, 1'b1, 32'h0040_0100);
        ex(S_PSM, 32'd0, "alloc_pcsrcPM");
        ex(S_MIS, 32'd1, "alloc_mispred");
        ex(S_CPC, 32'h0040_0100, "alloc_correct_pc");
        ex(S_HIT, 32'd0, "alloc_same_cycle_miss");
        ex(S_PPC, 32'h0040_0014, "alloc_same_cycle_ppc");
        ex(S_HM, 32'd4, "hashM_10");
        cyc();
        setM(1'b0, 32'h0, 1'b0, 32'h0);
        ex(S_HIT, 32'd1, "alloc_hit");
        ex(S_TAKEN, 32'd1, "alloc_taken");
        ex(S_PPC, 32'h0040_0100, "alloc_pred_pc");
        cyc();

        // Carry that prediction to M, resolve not-taken
        setF(32'h0040_0200, 1'b0);
        ex(S_HIT, 32'd0, "miss_200");
        ex(S_PPC, 32'h0040_0204, "miss_200_ppc");
        cyc();
        cyc();
        setM(1'b1, 32'h0040_0010, 1'b0, 32'h0040_0100);
        ex(S_PSM, 32'd1, "wrongdir_pcsrcPM");
        ex(S_MIS, 32'd1, "wrongdir_mispred");
        ex(S_CPC, 32'h0040_0018, "wrongdir_correct_pc");
        cyc();
        setM(1'b0, 32'h0, 1'b0, 32'h0);
        setF(32'h0040_0010, 1'b1);
        ex(S_HIT, 32'd1, "nottaken_keeps_entry");
        ex(S_PPC, 32'h0040_0100, "nottaken_keeps_target");
        ex(S_PSM, 32'd0, "after_wrongdir_pcsrcPM");
        cyc();

        // Set conflict in set 4
        setF(32'h0040_0200, 1'b0);
        setM(1'b1, 32'h0040_0090, 1'b1, 32'h0040_0900);
        ex(S_CPC, 32'h0040_0900, "train90_cpc");
        cyc();
        setM(1'b1, 32'h0040_0110, 1'b1, 32'h0040_1100);
        cyc();
        setM(1'b0, 32'h0, 1'b0, 32'h0);
        setF(32'h0040_0010, 1'b1);
        ex(S_HIT, 32'd0, "evicted_10");
        ex(S_PPC, 32'h0040_0014, "evicted_10_ppc");
        cyc();
        setF(32'h0040_0090, 1'b1);
        ex(S_HIT, 32'd1, "kept_90");
        ex(S_PPC, 32'h0040_0900, "kept_90_ppc");
        cyc();
        setF(32'h0040_0110, 1'b1);
        ex(S_HIT, 32'd1, "new_110");
        ex(S_PPC, 32'h0040_1100, "new_110_ppc");
        cyc();

        // Retarget hit in way 1 refreshes LRU, so next allocation evicts way 0
        setF(32'h0040_0200, 1'b0);
        setM(1'b1, 32'h0040_0090, 1'b1, 32'h0040_0A00);
        cyc();
        setM(1'b1, 32'h0040_0010, 1'b1, 32'h0040_0300);
        cyc();
        setM(1'b0, 32'h0, 1'b0, 32'h0);
        setF(32'h0040_0110, 1'b1);
        ex(S_HIT, 32'd0, "lru_evicted_110");
        cyc();
        setF(32'h0040_0010, 1'b1);
        ex(S_PPC, 32'h0040_0300, "lru_realloc_10");
        cyc();
        setF(32'h0040_0090, 1'b1);
        ex(S_PPC, 32'h0040_0A00, "retarget_90");
        cyc();

        // Stall D for two cycles holding the 0x90 prediction
        bus.stallD = 1'b1;
        setF(32'h0040_0200, 1'b0);
        cyc();
        cyc();
        bus.stallD = 1'b0;
        ex(S_PSM, 32'd1, "stall_psm_a");
        cyc();
        setM(1'b1, 32'h0040_0090, 1'b1, 32'h0040_0A00);
        ex(S_PSM, 32'd1, "stall_psm_b");
        ex(S_MIS, 32'd0, "correct_pred_mispred");
        ex(S_CPC, 32'h0040_0A00, "correct_pred_cpc");
        cyc();
        setM(1'b0, 32'h0, 1'b0, 32'h0);
        ex(S_PSM, 32'd1, "stall_psm_c");
        cyc();
        ex(S_PSM, 32'd0, "stall_psm_drain");
        cyc();

        // Flush D wins over stall D
        setF(32'h0040_0090, 1'b1);
        cyc();
        setF(32'h0040_0200, 1'b0);
        bus.flushD = 1'b1;
        bus.stallD = 1'b1;
        cyc();
        bus.flushD = 1'b0;
        cyc();
        bus.stallD = 1'b0;
        ex(S_PSM, 32'd1, "flushD_older_psm");
        cyc();
        ex(S_PSM, 32'd0, "flushD_psm");
        cyc();

        // Flush E
        setF(32'h0040_0090, 1'b1);
        cyc();
        setF(32'h0040_0200, 1'b0);
        bus.flushE = 1'b1;
        cyc();
        bus.flushE = 1'b0;
        cyc();
        ex(S_PSM, 32'd0, "flushE_psm");
        ex(S_MIS, 32'd0, "flushE_nobranch_mispred");
        cyc();

        // Flush M
        setF(32'h0040_0090, 1'b1);
        cyc();
        setF(32'h0040_0200, 1'b0);
        cyc();
        bus.flushM = 1'b1;
        cyc();
        bus.flushM = 1'b0;
        ex(S_PSM, 32'd0, "flushM_psm");
        cyc();

        // Same-cycle train and lookup: no bypass
        setF(32'h0040_0020, 1'b1);
        setM(1'b1, 32'h0040_0020, 1'b1, 32'h0040_0500);
        ex(S_HIT, 32'd0, "simul_miss");
        ex(S_PPC, 32'h0040_0024, "simul_miss_ppc");
        ex(S_CPC, 32'h0040_0500, "simul_cpc");
        cyc();
        setM(1'b0, 32'h0, 1'b0, 32'h0);
        ex(S_HIT, 32'd1, "simul_hit_next");
        ex(S_TAKEN, 32'd1, "simul_taken_next");
        ex(S_PPC, 32'h0040_0500, "simul_ppc_next");
        cyc();
        setF(32'h0040_0020, 1'b0);
        ex(S_HIT, 32'd1, "hit_nottaken_hit");
        ex(S_TAKEN, 32'd0, "hit_nottaken_taken");
        ex(S_PPC, 32'h0040_0024, "hit_nottaken_ppc");
        cyc();

        // Reset wins over training
        rst = 1'b1;
        setF(32'h0040_0040, 1'b1);
        setM(1'b1, 32'h0040_0040, 1'b1, 32'h0040_0700);
        cyc();
        rst = 1'b0;
        setM(1'b0, 32'h0, 1'b0, 32'h0);
        setF(32'h0040_0020, 1'b1);
        ex(S_HIT, 32'd0, "rst_clears_btb");
        ex(S_PPC, 32'h0040_0024, "rst_clears_ppc");
        ex(S_PSM, 32'd0, "rst_clears_pipe");
        cyc();
        setF(32'h0040_0040, 1'b1);
        ex(S_HIT, 32'd0, "rst_blocks_train");
        cyc();

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bp_btb_fetch.md
# bp_btb_fetch

Fetch-stage branch target buffer and next-PC predictor paired with the global-history direction predictor. Each cycle it hashes `pcF` for the predictor's PHT index and looks up a 2-way set-associative BTB. It combines a BTB hit with the predictor's `pcsrcPF` to produce the predicted next PC. The prediction is carried down the pipeline to M, where the block checks it against the resolved branch, flags a mispredict with the correct PC, and trains the BTB.

## Interface
- `SET_W`, 5: log2 of the number of BTB sets; 32 sets × 2 ways.
- `HASH_W`, 3: width of `hashed_pcF`/`hashed_pcM`; equals PHT depth minus GHR width.
- `FALLTHRU`, 8: byte offset from a branch PC to its not-taken successor, covering the delay slot.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high; clock `clk`.
- `pcF` in 32: fetch PC, word aligned.
- `pcsrcPF` in 1: direction prediction from the predictor for `hashed_pcF`.
- `hashed_pcF` out HASH_W: PC hash sent to the predictor.
- `btb_hitF` out 1: valid tag match for `pcF`.
- `pred_takenF` out 1: equals `btb_hitF & pcsrcPF`.
- `pred_pcF` out 32: predicted next PC.
- `stallD` in 1: hold the F→D prediction register.
- `flushD`, `flushE`, `flushM` in 1: clear the prediction register entering D, E or M.
- `branchM` in 1: the M-stage instruction is a conditional branch.
- `pcM` in 32: M-stage PC.
- `pcsrcM` in 1: resolved direction.
- `targetM` in 32: resolved branch target.
- `hashed_pcM` out HASH_W: hash of `pcM` sent to the predictor.
- `pcsrcPM` out 1: predicted taken, as carried to M.
- `mispredM` out 1: misprediction detected in M.
- `correct_pcM` out 32: redirect PC, meaningful only when `mispredM` is 1.

## Operation
- **Hash:** `hash(pc) = pc[HASH_W+1:2] ^ pc[2*HASH_W+1:HASH_W+2]`, applied to both `pcF` and `pcM`.
- **Address split:**
  - Set index is `pc[SET_W+1:2]`.
  - Tag is `pc[31:SET_W+2]` (full tag, no aliasing).
- **Entry contents:** `valid`, `tag`, 32-bit `target`, plus one `lru` bit per set.
  - `lru` names the way to replace next.
- **F lookup (combinational, asynchronous read):**
  - A hit is a valid entry whose tag matches. Both ways never hit simultaneously.
  - `pred_pcF` is the hit way's `target` when `pred_takenF`, otherwise `pcF+4`.
  - Lookups never change `lru`.
- **Prediction pipeline:** carries `{pred_taken, pred_pc}` through F→D→E→M.
  - D register: holds when `stallD`; cleared when `flushD` (flush wins over stall).
  - E and M registers: cleared when `flushE` or `flushM` respectively; otherwise they load every cycle.
  - `pcsrcPM` is the M-stage copy of `pred_taken`.
- **Resolution in M:**
  - `mispredM = branchM & ((pcsrcPM != pcsrcM) | (pcsrcM & pred_pcM != targetM))`.
  - `correct_pcM = pcsrcM ? targetM : pcM+FALLTHRU`.
  - When `branchM` is 0, `mispredM` is 0.
- **Training:** occurs when `branchM & pcsrcM`; not-taken branches never write.
  - On a hit in way w: `target <= targetM`, `lru <= ~w`.
  - On a miss, the victim is the first invalid way (way 0 before way 1), else the `lru` way. The victim is written with `valid=1`, tag and target, and `lru <= ~victim`.

## Timing
- F outputs and M resolution outputs are combinational; there is no extra latency.
- BTB writes take effect at the clock edge, so a lookup in the same cycle as a write to the same set sees the old contents. There is no bypass.
- Reset values:
  - All valid bits and `lru` bits are 0.
  - All pipeline registers are 0.
  - Therefore `btb_hitF=0`, `pred_pcF=pcF+4`, `pcsrcPM=0` and `mispredM=0` after reset.
- Reset asserted mid-operation wins over training and stall in the same cycle.
- A flush and a training write in the same cycle are independent: training still happens, using the M values present before the edge.

## Structure
- Shared package `bp_pkg`:
  - `btb_entry_t` struct `{valid, tag, target}`.
  - `pred_t` struct `{taken, pc}`.
  - Default constants `SET_W`, `HASH_W`, `FALLTHRU`.
  - `bp_hash()` function, which the predictor also uses.
- One sub-module, `bp_btb_array`: storage, asynchronous 2-way lookup, and victim/LRU write logic.
- The top level holds hashing, next-PC mux, prediction pipeline and M-stage checking.

## Test plan
- **Reset:** after reset, with `pcF=0x00400000` and `pcsrcPF=1` → `btb_hitF=0`, `pred_pcF=0x00400004`, `mispredM=0`.
- **Allocate then hit:**
  - M presents `pcM=0x00400010`, `pcsrcM=1`, `targetM=0x00400100` → `mispredM=1`, `correct_pcM=0x00400100`.
  - Next cycle, with `pcF=0x00400010` and `pcsrcPF=1` → `pred_pcF=0x00400100`.
- **Wrong direction:** the BTB hit entry from the previous scenario is carried to M with `pcsrcPM=1`; `branchM=1`, `pcsrcM=0` → `mispredM=1`, `correct_pcM=0x00400018`, and the entry is unchanged.
- **Set conflict:**
  - Train PCs `0x00400010`, `0x00400090` and `0x00400110` (all set 4), all taken.
  - Third allocation evicts way 0, holding `0x00400010`.
  - `0x00400090` still hits.
- **Hazards:**
  - With `stallD` held for 2 cycles, the D prediction is unchanged.
  - `flushE` → `pcsrcPM=0` two cycles later; `branchM=0` → `mispredM=0`.
- **Simultaneous access:** in one cycle, train `pcM=0x00400020` (taken) while looking up `pcF=0x00400020` → a miss this cycle, a hit the next cycle.
